// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared state encodings and widths for the arbitrated adder
package sumador_pkg;

    localparam int N_OP  = 9;
    localparam int N_S   = 10;
    localparam int N_CNT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUMA    = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

endpackage

// File: rtl/RCA_aproximado9b_1.sv
// rtl/RCA_aproximado9b_1.sv - 9-bit ripple-carry adder, 4 approximate LSB stages, 5 exact MSB stages
module RCA_aproximado9b_1
    import sumador_pkg::*;
(
    input  logic [N_OP-1:0] A,
    input  logic [N_OP-1:0] B,
    output logic [N_S-1:0]  S
);

    logic c;

    // Approximate cells ignore their carry-in: sum = a^b, carry-out = a&b.
    always_comb begin
        S = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S[i] = A[i] ^ B[i];
            c    = A[i] & B[i];
        end
        for (int i = 4; i < N_OP; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        S[N_S-1] = c;
    end

endmodule

// File: rtl/sumador_arbitrado.sv
// rtl/sumador_arbitrado.sv - two requesters share one approximate adder via round-robin arbitration
module sumador_arbitrado
    import sumador_pkg::*;
#(
    parameter int PTR_INICIAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [N_OP-1:0]  req0_A,
    input  logic [N_OP-1:0]  req0_B,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N_OP-1:0]  req1_A,
    input  logic [N_OP-1:0]  req1_B,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_S-1:0]   out_S,
    output logic             out_id,
    output logic [N_CNT-1:0] cnt0,
    output logic [N_CNT-1:0] cnt1
);

    estado_t          state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [N_OP-1:0]  a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [N_S-1:0]   s_q, s_d;
    logic [N_CNT-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [N_S-1:0]   suma;
    logic             grant0, grant1;

    RCA_aproximado9b_1 u_rca (
        .A (a_q),
        .B (b_q),
        .S (suma)
    );

    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && (!req0_valid ||  ptr_q);

    // rst gates ready directly so no handshake can be seen while reset is held.
    assign req0_ready = !rst && (state_q == IDLE) && grant0;
    assign req1_ready = !rst && (state_q == IDLE) && grant1;

    assign out_valid = (state_q == ENTREGA);
    assign out_S     = s_q;
    assign out_id    = id_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        s_d     = s_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    a_d     = req0_A;
                    b_d     = req0_B;
                    id_d    = 1'b0;
                    state_d = SUMA;
                end else if (req1_ready) begin
                    a_d     = req1_A;
                    b_d     = req1_B;
                    id_d    = 1'b1;
                    state_d = SUMA;
                end
            end
            SUMA: begin
                s_d     = suma;
                state_d = ENTREGA;
            end
            ENTREGA: begin
                if (out_ready) begin
                    ptr_d   = ~id_q;
                    state_d = IDLE;
                    if (id_q) cnt1_d = cnt1_q + 8'd1;
                    else      cnt0_d = cnt0_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'(PTR_INICIAL);
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            s_q     <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            s_q     <= s_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_sumador_arbitrado.sv
// tb/tb_sumador_arbitrado.sv - directed self-checking bench for sumador_arbitrado
module tb_sumador_arbitrado;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [8:0] req0_A, req0_B, req1_A, req1_B;
    logic       out_valid, out_ready, out_id;
    logic [9:0] out_S;
    logic [7:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sumador_arbitrado #(.PTR_INICIAL(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_S      (out_S),
        .out_id     (out_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic v0, input logic v1,
                          input logic [8:0] a0, input logic [8:0] b0,
                          input logic [8:0] a1, input logic [8:0] b1,
                          input logic exp_id, input logic [9:0] exp_s,
                          input logic drop);
        int n;
        req0_valid = v0; req0_A = a0; req0_B = b0;
        req1_valid = v1; req1_A = a1; req1_B = b1;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 8) begin
            step();
            n++;
        end
        if (n >= 8) chk({tag, "_grant_timeout"}, 1, 0);
        chk({tag, "_grant_id"}, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
        step();
        if (drop) begin
            if (exp_id) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        chk({tag, "_suma_nvalid"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_S"}, out_S, exp_s);
        chk({tag, "_id"}, out_id, exp_id);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_A = 9'h1FF; req0_B = 9'h1FF;
        req1_valid = 1'b1; req1_A = 9'h1FF; req1_B = 9'h1FF;
        step();
        step();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_S", out_S, 0);
        chk("rst_cnts", {cnt1, cnt0}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // Both valid straight out of reset: requester 0 first, then 1.
        run_op("both_a", 1, 1, 9'h1F0, 9'h1F0, 9'h110, 9'h1F0, 0, 10'h3E0, 1);
        run_op("both_b", 0, 1, 9'h1F0, 9'h1F0, 9'h110, 9'h1F0, 1, 10'h300, 1);
        chk("both_cnts", {cnt1, cnt0}, {8'd1, 8'd1});

        run_op("solo0", 1, 0, 9'h100, 9'h0F0, 9'h000, 9'h000, 0, 10'h1F0, 1);
        chk("solo0_cnt0", cnt0, 2);

        // Low nibble goes through the approximate cells: 0x00F+0x001 -> 0x00E.
        run_op("aprox", 1, 0, 9'h00F, 9'h001, 9'h000, 9'h000, 0, 10'h00E, 1);
        run_op("carry", 0, 1, 9'h000, 9'h000, 9'h1FF, 9'h010, 1, 10'h20F, 1);

        // Stall in ENTREGA for 5 cycles with both requesters waiting.
        req0_valid = 1'b1; req0_A = 9'h055; req0_B = 9'h020;
        req1_valid = 1'b0;
        #1;
        chk("stall_grant", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_A = 9'h033; req1_B = 9'h044;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_S", out_S, 10'h075);
            chk("stall_id", out_id, 0);
            chk("stall_readys", {req1_ready, req0_ready}, 0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall_cnt0", cnt0, 4);

        // A valid that disappears before any grant leaves no trace.
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("drop_nvalid", out_valid, 0);
        chk("drop_cnts", {cnt1, cnt0}, {8'd2, 8'd4});

        // Reset in the middle of SUMA discards the operation.
        req1_valid = 1'b1; req1_A = 9'h100; req1_B = 9'h100;
        step();
        req1_valid = 1'b0;
        chk("rstmid_in_suma", out_valid, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_out_S", out_S, 0);
        chk("rstmid_out_id", out_id, 0);
        chk("rstmid_cnts", {cnt1, cnt0}, 0);
        step();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_no_valid", out_valid, 0);
        end
        out_ready = 1'b0;
        chk("rstmid_cnts_after", {cnt1, cnt0}, 0);

        // One req0 op, then 256 req1 ops: cnt1 wraps, cnt0 stays at 1.
        run_op("pre0", 1, 0, 9'h001, 9'h010, 9'h000, 9'h000, 0, 10'h011, 1);
        for (int i = 0; i < 256; i++) begin
            run_op("wrap", 0, 1, 9'h000, 9'h000, 9'h020, 9'h010, 1, 10'h030, 1);
            if (i == 254) chk("wrap_255", cnt1, 255);
        end
        chk("wrap_cnt1", cnt1, 0);
        chk("wrap_cnt0", cnt0, 1);

        // Continuous contention alternates grants starting with 0.
        for (int i = 0; i < 6; i++) begin
            run_op("alt", 1, 1, 9'h011, 9'h022, 9'h044, 9'h088,
                   (i % 2) == 1, ((i % 2) == 1) ? 10'h0CC : 10'h033, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_cnts", {cnt1, cnt0}, {8'd3, 8'd4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
